io_write_demux: RTL and testbench
=================================

// Module: io_write_demux
// PURPOSE
//  Write-side counterpart of the I/O read multiplexor: takes one T-bit write from the core and routes it
//  into one of R registered I/O output slots, selected by address. Each slot carries a "new data" flag
//  the peripheral (e.g. UART TX) clears with an ack. Sits between the core's I/O store path and the peripherals.
// PARAMETERS
//  R  2  number of I/O output slots
//  T  8  bits per slot
//  N  1  selection width; must satisfy 2**N >= R
// PORTS
//  clk        in   1    single clock, rising edge
//  reset_n    in   1    asynchronous, active-low reset
//  selection  in   N    target slot index for the write
//  datain     in   T    write data
//  wr_en      in   1    write request; a write is accepted in a cycle where wr_en && wr_ready
//  wr_ready   out  1    combinational: slot can accept this cycle
//  wr_error   out  1    registered one-cycle pulse: write to selection >= R
//  dataout    out  R*T  slot k on dataout[k*T +: T], registered
//  data_new   out  R    bit k set: slot k holds data not yet acknowledged
//  data_ack   in   R    bit k: peripheral consumed slot k (ignored when data_new[k]=0)
// BEHAVIOUR
//  - Reset (reset_n=0, any time, async): dataout=0, data_new=0, wr_error=0; a write in progress is lost.
//  - wr_ready = (selection >= R) | ~data_new[selection] | data_ack[selection].
//  - Accepted write to slot s<R: next edge dataout[s]=datain, data_new[s]=1; other slots unchanged.
//    Latency 1 cycle from acceptance to dataout/data_new visible.
//  - wr_en with wr_ready=0: no state change; core holds selection/datain/wr_en until wr_ready=1.
//  - data_ack[k] with data_new[k]=1 and no accepted write to k: data_new[k] clears next edge.
//  - Same-cycle ack and accepted write to same slot: new data loaded, data_new stays 1 (write wins).
//  - Same-cycle ack on slot j and write to slot k (j!=k): both take effect independently.
//  - selection >= R with wr_en: write accepted and dropped, no slot changes, wr_error=1 next cycle only.
//  - wr_error clears the following cycle unless another out-of-range write is accepted.
//  - Each slot is a 2-state machine: EMPTY (data_new=0) -> FULL on write; FULL -> EMPTY on ack w/o write;
//    FULL -> FULL on write+ack; FULL + write w/o ack is stalled (never reached).
//  - No overwrite of unacknowledged data is possible; dataout keeps its value after ack (sticky).
// STRUCTURE
//  - Shared header io_map.vh: defaults for R/T/N and named slot indices (IO_SLOT_UART_TX=0,
//    IO_SLOT_LED=1), also used by the read multiplexor so both ends agree on the address map.
//  - Sub-module io_write_slot (T-bit data reg + data_new flag, inputs wr, ack, din), instantiated R
//    times via generate; top level holds address decode, wr_ready mux and wr_error register.
// TESTING
//  1 Reset: hold reset_n=0 mid-run after writes -> dataout=0, data_new=00, wr_error=0 immediately (async).
//  2 Write sel=0 data=8'hA5 wr_en 1 cycle -> next cycle dataout[7:0]=A5, data_new=01, dataout[15:8]=00.
//  3 Slot 0 FULL, write sel=0 data=8'h3C without ack -> wr_ready=0, dataout[7:0] stays A5 until
//    data_ack=01 asserted; that cycle write accepted, next cycle dataout[7:0]=3C, data_new=01.
//  4 Slot 1 FULL, data_ack=10 while writing sel=0 data=8'h11 -> next cycle data_new=01, dataout[7:0]=11.
//  5 R=3,N=2: write sel=3 data=8'hFF -> wr_ready=1, wr_error=1 for exactly one cycle, slots unchanged.
//  6 data_ack=11 with data_new=00 -> no change; random write/ack stress vs. reference model, no lost data.

Source files
------------

// File: rtl/io_write_demux_pkg.sv
// Shared address map and slot state type for the I/O write demultiplexer.
// The read multiplexor imports the same package so both ends agree on
// which slot index belongs to which peripheral.
package io_write_demux_pkg;

   // Default geometry: two 8-bit slots addressed by a 1-bit selection.
   localparam int IO_R_DEFAULT = 2;
   localparam int IO_T_DEFAULT = 8;
   localparam int IO_N_DEFAULT = 1;

   // Named slot indices of the I/O map.
   localparam int IO_SLOT_UART_TX = 0;
   localparam int IO_SLOT_LED     = 1;

   // Per-slot state: FULL means the slot holds data the peripheral has not yet acknowledged.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/io_write_demux_slot.sv
// One registered I/O output slot: T-bit data register plus an EMPTY/FULL
// state that tracks whether the peripheral has consumed the data yet.
// The top only raises wr_i when the slot is EMPTY or is being acked in the
// same cycle, so FULL + write without ack never happens here.
module io_write_slot
   import io_write_demux_pkg::*;
#(
   parameter int T = IO_T_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_i,
   input  logic        ack_i,
   input  logic [T-1:0] din_i,
   output logic [T-1:0] dout_o,
   output slot_state_e  state_o
);

   logic [T-1:0] data_q;
   slot_state_e  state_q;

   // Slot FSM: a write loads data and marks FULL (write wins over a same-cycle
   // ack); an ack without a write empties the slot but leaves the data sticky.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         case (state_q)
            SLOT_EMPTY: begin
               if (wr_i) begin
                  data_q  <= din_i;
                  state_q <= SLOT_FULL;
               end
            end
            SLOT_FULL: begin
               if (wr_i) begin
                  data_q <= din_i;
               end else if (ack_i) begin
                  state_q <= SLOT_EMPTY;
               end
            end
            default: state_q <= SLOT_EMPTY;
         endcase
      end
   end

   assign dout_o  = data_q;
   assign state_o = state_q;

endmodule

// File: rtl/io_write_demux.sv
// I/O write demultiplexer: routes one T-bit core write into one of R
// registered output slots selected by address.
// Handshake: a write is accepted in any cycle where wr_en && wr_ready; while
// wr_ready is low the core holds selection/datain/wr_en unchanged. wr_ready
// is combinational and is high for out-of-range selections (those writes are
// swallowed and flagged by a one-cycle wr_error pulse), for an EMPTY target
// slot, or for a FULL target slot that is being acked this very cycle.
module io_write_demux
   import io_write_demux_pkg::*;
#(
   parameter int R = IO_R_DEFAULT,
   parameter int T = IO_T_DEFAULT,
   parameter int N = IO_N_DEFAULT
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [N-1:0]   selection,
   input  logic [T-1:0]   datain,
   input  logic           wr_en,
   output logic           wr_ready,
   output logic           wr_error,
   output logic [R*T-1:0] dataout,
   output logic [R-1:0]   data_new,
   input  logic [R-1:0]   data_ack
);

   logic         sel_valid;
   logic         sel_new;
   logic         sel_ack;
   logic         accept;
   logic [R-1:0] slot_wr;
   logic         wr_error_q;
   slot_state_e  slot_state [R];

   assign sel_valid = ({{(32-N){1'b0}}, selection} < 32'(R));

   // Pick the flag and ack of the addressed slot; out-of-range selections read as zero.
   always_comb begin
      sel_new = 1'b0;
      sel_ack = 1'b0;
      for (int k = 0; k < R; k++) begin
         if (selection == N'(k)) begin
            sel_new = data_new[k];
            sel_ack = data_ack[k];
         end
      end
   end

   assign wr_ready = !sel_valid || !sel_new || sel_ack;
   assign accept   = wr_en && wr_ready;

   // Address decode: one-hot write strobe for the slot that accepts this cycle.
   always_comb begin
      slot_wr = '0;
      for (int k = 0; k < R; k++) begin
         slot_wr[k] = accept && (selection == N'(k));
      end
   end

   // Out-of-range accepted writes raise wr_error for exactly the next cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_error_q <= 1'b0;
      end else begin
         wr_error_q <= accept && !sel_valid;
      end
   end

   assign wr_error = wr_error_q;

   for (genvar k = 0; k < R; k++) begin : g_slot
      io_write_slot #(
         .T (T)
      ) u_slot (
         .clk     (clk),
         .reset_n (reset_n),
         .wr_i    (slot_wr[k]),
         .ack_i   (data_ack[k]),
         .din_i   (datain),
         .dout_o  (dataout[k*T +: T]),
         .state_o (slot_state[k])
      );

      assign data_new[k] = (slot_state[k] == SLOT_FULL);
   end

endmodule

// File: tb/tb_io_write_demux.sv
// Bench for io_write_demux: directed scenarios plus randomized write/ack
// traffic, checked every cycle against a slot-level reference model and a
// per-slot queue of written data that every acknowledged value must match.
module tb_io_write_demux;

   localparam int R = 2;
   localparam int T = 8;
   localparam int N = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // ---------------- DUT (R=2) signals ----------------
   logic [N-1:0]   selection;
   logic [T-1:0]   datain;
   logic           wr_en;
   logic           wr_ready;
   logic           wr_error;
   logic [R*T-1:0] dataout;
   logic [R-1:0]   data_new;
   logic [R-1:0]   data_ack;

   // ---------------- second instance (R=3, N=2) ----------------
   logic [1:0]  s3_selection;
   logic [7:0]  s3_datain;
   logic        s3_wr_en;
   logic        s3_wr_ready;
   logic        s3_wr_error;
   logic [23:0] s3_dataout;
   logic [2:0]  s3_data_new;
   logic [2:0]  s3_data_ack;

   io_write_demux #(.R(R), .T(T), .N(N)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .selection (selection),
      .datain    (datain),
      .wr_en     (wr_en),
      .wr_ready  (wr_ready),
      .wr_error  (wr_error),
      .dataout   (dataout),
      .data_new  (data_new),
      .data_ack  (data_ack)
   );

   io_write_demux #(.R(3), .T(8), .N(2)) dut3 (
      .clk       (clk),
      .reset_n   (reset_n),
      .selection (s3_selection),
      .datain    (s3_datain),
      .wr_en     (s3_wr_en),
      .wr_ready  (s3_wr_ready),
      .wr_error  (s3_wr_error),
      .dataout   (s3_dataout),
      .data_new  (s3_data_new),
      .data_ack  (s3_data_ack)
   );

   // ---------------- bookkeeping ----------------
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [T-1:0] m_data [R];
   logic         m_new  [R];
   logic         m_err;

   function automatic logic ref_ready();
      if (int'(selection) >= R) return 1'b1;
      return !m_new[selection] || data_ack[selection];
   endfunction

   function automatic logic accepted();
      return wr_en && ref_ready();
   endfunction

   function automatic logic [R*T-1:0] exp_dataout();
      logic [R*T-1:0] v;
      v = '0;
      for (int k = 0; k < R; k++) v[k*T +: T] = m_data[k];
      return v;
   endfunction

   function automatic logic [R-1:0] exp_new();
      logic [R-1:0] v;
      v = '0;
      for (int k = 0; k < R; k++) v[k] = m_new[k];
      return v;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < R; k++) begin
            m_data[k] <= '0;
            m_new[k]  <= 1'b0;
         end
         m_err <= 1'b0;
      end else begin
         m_err <= accepted() && (int'(selection) >= R);
         for (int k = 0; k < R; k++) begin
            if (accepted() && int'(selection) == k) begin
               m_data[k] <= datain;
               m_new[k]  <= 1'b1;
            end else if (data_ack[k]) begin
               m_new[k] <= 1'b0;
            end
         end
      end
   end

   // ---------------- scoreboard: written data must all be acknowledged in order ----------------
   logic [T-1:0] exp_q [R][$];

   always @(negedge reset_n) begin
      for (int k = 0; k < R; k++) exp_q[k].delete();
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      check("dataout", 32'(dataout), 32'(exp_dataout()));
      check("data_new", 32'(data_new), 32'(exp_new()));
      check("wr_error", 32'(wr_error), 32'(m_err));
      check("wr_ready", 32'(wr_ready), 32'(ref_ready()));
      if (reset_n) begin
         for (int k = 0; k < R; k++) begin
            if (data_ack[k] && m_new[k]) begin
               if (exp_q[k].size() == 0) begin
                  check("sb_underflow", 32'(1), 32'(0));
               end else begin
                  check("sb_consumed", 32'(dataout[k*T +: T]), 32'(exp_q[k].pop_front()));
               end
            end
         end
         if (accepted() && int'(selection) < R) exp_q[selection].push_back(datain);
      end
   end

   // ---------------- driver helpers ----------------
   task automatic drive(input logic we, input logic [N-1:0] sel, input logic [T-1:0] d,
                        input logic [R-1:0] ack);
      @(posedge clk);
      #1;
      wr_en     = we;
      selection = sel;
      datain    = d;
      data_ack  = ack;
   endtask

   task automatic drive3(input logic we, input logic [1:0] sel, input logic [7:0] d);
      @(posedge clk);
      #1;
      s3_wr_en     = we;
      s3_selection = sel;
      s3_datain    = d;
   endtask

   // ---------------- stimulus ----------------
   logic stall;

   initial begin
      reset_n      = 1'b0;
      wr_en        = 1'b0;
      selection    = '0;
      datain       = '0;
      data_ack     = '0;
      s3_wr_en     = 1'b0;
      s3_selection = '0;
      s3_datain    = '0;
      s3_data_ack  = '0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_dataout", 32'(dataout), 32'h0);
      check("rst_data_new", 32'(data_new), 32'h0);
      check("rst_wr_error", 32'(wr_error), 32'h0);

      // Single write to slot 0
      drive(1'b1, 1'b0, 8'hA5, 2'b00);
      drive(1'b0, 1'b0, 8'h00, 2'b00);
      @(negedge clk);
      check("t2_dataout", 32'(dataout), 32'h00A5);
      check("t2_data_new", 32'(data_new), 32'h1);

      // Overwrite attempt stalls until ack; write wins over same-cycle ack
      drive(1'b1, 1'b0, 8'h3C, 2'b00);
      @(negedge clk);
      check("t3_stall_ready", 32'(wr_ready), 32'h0);
      drive(1'b1, 1'b0, 8'h3C, 2'b00);
      @(negedge clk);
      check("t3_held_data", 32'(dataout[7:0]), 32'hA5);
      drive(1'b1, 1'b0, 8'h3C, 2'b01);
      @(negedge clk);
      check("t3_ack_ready", 32'(wr_ready), 32'h1);
      drive(1'b0, 1'b0, 8'h00, 2'b00);
      @(negedge clk);
      check("t3_dataout", 32'(dataout[7:0]), 32'h3C);
      check("t3_data_new", 32'(data_new), 32'h1);

      // Ack on one slot while writing the other
      drive(1'b1, 1'b1, 8'h77, 2'b01);
      drive(1'b0, 1'b0, 8'h00, 2'b00);
      @(negedge clk);
      check("t4_setup_new", 32'(data_new), 32'h2);
      check("t4_setup_data", 32'(dataout), 32'h773C);
      drive(1'b1, 1'b0, 8'h11, 2'b10);
      drive(1'b0, 1'b0, 8'h00, 2'b00);
      @(negedge clk);
      check("t4_data_new", 32'(data_new), 32'h1);
      check("t4_dataout", 32'(dataout), 32'h7711);

      // Acks on empty slots change nothing; data stays sticky
      drive(1'b0, 1'b0, 8'h00, 2'b01);
      drive(1'b0, 1'b0, 8'h00, 2'b11);
      drive(1'b0, 1'b0, 8'h00, 2'b00);
      @(negedge clk);
      check("t6_data_new", 32'(data_new), 32'h0);
      check("t6_dataout", 32'(dataout), 32'h7711);

      // Out-of-range write on the 3-slot instance
      drive3(1'b1, 2'd2, 8'hC3);
      drive3(1'b1, 2'd3, 8'hFF);
      #1;
      check("t5_ready", 32'(s3_wr_ready), 32'h1);
      drive3(1'b0, 2'd0, 8'h00);
      @(negedge clk);
      check("t5_error_on", 32'(s3_wr_error), 32'h1);
      check("t5_dataout", 32'(s3_dataout), 32'hC30000);
      check("t5_data_new", 32'(s3_data_new), 32'h4);
      @(negedge clk);
      check("t5_error_off", 32'(s3_wr_error), 32'h0);

      // Randomized write/ack traffic; a stalled write is held until accepted
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         stall = wr_en && !ref_ready();
         @(posedge clk);
         #1;
         if (!stall) begin
            wr_en     = 1'($urandom_range(0, 1));
            selection = N'($urandom_range(0, R - 1));
            datain    = T'($urandom_range(0, 255));
         end
         for (int k = 0; k < R; k++) data_ack[k] = ($urandom_range(0, 3) == 0);
      end

      // Drain: ack everything, then every written value must have been consumed
      @(negedge clk);
      stall = wr_en && !ref_ready();
      for (int i = 0; i < 20 && stall; i++) begin
         drive(wr_en, selection, datain, '1);
         @(negedge clk);
         stall = wr_en && !ref_ready();
      end
      check("drain_no_stall", 32'(stall), 32'h0);
      drive(1'b0, '0, '0, '1);
      drive(1'b0, '0, '0, '1);
      drive(1'b0, '0, '0, '0);
      @(negedge clk);
      for (int k = 0; k < R; k++) check("sb_drained", 32'(exp_q[k].size()), 32'h0);

      // Asynchronous reset mid-cycle after fresh writes
      drive(1'b1, 1'b1, 8'h5A, 2'b00);
      drive(1'b1, 1'b0, 8'h96, 2'b00);
      drive(1'b0, 1'b0, 8'h00, 2'b00);
      #2 reset_n = 1'b0;
      #1;
      check("t1_dataout", 32'(dataout), 32'h0);
      check("t1_data_new", 32'(data_new), 32'h0);
      check("t1_wr_error", 32'(wr_error), 32'h0);
      check("t1_s3_data_new", 32'(s3_data_new), 32'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
